lag_generator_fir: RTL
======================

Name: lag_generator_fir

Overview:
Parametrised, fixed-point successor to the 16-tap double-precision lag generator. It synthesises an echo signal_lag = sum over k of coef[k]*x[n-k] from a TAPS-deep circular sample history. The matching undelayed sample is output as signal_align. It sits between the signal source and echo_cancelation_full as the bench and reference echo path. It uses one shared multiply-accumulate unit, processing one tap per cycle.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
COEF_FRAC, 15, fractional bits of coefficients (Q1.15 by default)
TAPS, 16, number of taps and history depth (≥2, power of two not required)

Ports:
clk_operation  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  one-cycle sample strobe; signal is valid in this cycle
signal  in  DATA_W  signed input sample
flush  in  1  synchronous clear of sample history (coefficients kept)
sat_en  in  1  1 = saturate result, 0 = wrap (truncate to DATA_W)
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  clog2(TAPS)  tap index
coef_wr_data  in  COEF_W  signed coefficient
signal_lag  out  DATA_W  echo result
signal_align  out  DATA_W  input sample that produced signal_lag
ready  out  1  one-cycle pulse: new signal_lag/signal_align valid
busy  out  1  high while a computation is in progress
overrun  out  1  one-cycle pulse: enable dropped because busy
wr_reject  out  1  one-cycle pulse: coef write dropped (busy or addr ≥ TAPS)

Behaviour:
- Reset (rst=0, async):
  - history, coefficients, accumulator, head pointer, tap counter all 0
  - outputs 0; state IDLE
  - reset mid-computation aborts the computation and produces no ready pulse
- States are IDLE, MAC, ROUND.
- IDLE:
  - On enable: write signal to hist[head], latch it as pending align value, clear accumulator, set k=0, go to MAC; busy=1 from the next cycle.
  - flush and enable in the same cycle: history is cleared first, then the new sample is written (result uses only the new sample).
- MAC: each cycle accumulate acc += coef[k] * hist[(head - k) mod TAPS] and increment k.
  - After k = TAPS-1, go to ROUND.
  - Index wrap uses explicit compare/subtract, not a power-of-two mask.
- ROUND:
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift; round half up).
  - sat_en=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_en=0: take r[DATA_W-1:0].
  - Register signal_lag and signal_align, pulse ready, advance head (wrap TAPS-1 → 0), go to IDLE.
- Latency: enable at cycle 0 → ready high in cycle TAPS+2. Minimum enable spacing is TAPS+2 cycles.
- Output holding: signal_lag and signal_align hold their values until the next ready; ready is exactly one cycle wide.
- Accumulator width: ACC_W = DATA_W + COEF_W + clog2(TAPS); no internal overflow is possible.
- enable while busy: sample ignored, history untouched, overrun pulses, current computation unaffected.
- Coefficient writes:
  - Accepted only in IDLE with addr < TAPS; take effect on the next computation.
  - A write in the same cycle as an enable in IDLE is accepted, but the computation triggered by that enable uses the old value.
  - Otherwise wr_reject pulses.
- flush while busy is ignored; flush has no effect on outputs.
- sat_en is sampled in ROUND only.

Test Plan:
- Reset: assert rst=0 mid-MAC → all outputs 0 immediately, no ready after release; first enable afterwards behaves as after power-up.
- Impulse/latency: coef[0]=0x4000, others 0; enable with signal=1000 at cycle 0 → ready in cycle 18, signal_lag=500, signal_align=1000.
- Lag tap and wrap: coef[3]=0x7FFF only; feed 1000 then 40 samples of 0 → signal_lag=1000 on the 4th result only. Repeat after head has wrapped (>TAPS samples) → identical.
- Saturation vs wrap: coef[0]=coef[1]=0x7FFF; samples 30000, 30000 with sat_en=1 → second result 32767; same with sat_en=0 → -5538.
- Rounding/negative: coef[0]=0x4000, signal=-3 → -1 (round half up of -1.5); signal=3 → 2.
- Handshake errors: enable at cycle 5 after a cycle-0 enable → overrun pulse, result unchanged. Coef write while busy → wr_reject. Write addr=TAPS (TAPS<2^clog2) → wr_reject. flush then enable 500 with coef[1]=0x7FFF → result 0.

Source files
------------

// File: rtl/lag_generator_fir_if.sv
// rtl/lag_generator_fir_if.sv - sample, coefficient and result signals of the lag generator
interface lag_generator_fir_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                     enable;
    logic signed [DATA_W-1:0] signal;
    logic                     flush;
    logic                     sat_en;
    logic                     coef_wr_en;
    logic [AW-1:0]            coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic signed [DATA_W-1:0] signal_lag;
    logic signed [DATA_W-1:0] signal_align;
    logic                     ready;
    logic                     busy;
    logic                     overrun;
    logic                     wr_reject;

    modport master (
        output enable, signal, flush, sat_en, coef_wr_en, coef_wr_addr, coef_wr_data,
        input  signal_lag, signal_align, ready, busy, overrun, wr_reject
    );

    modport slave (
        input  enable, signal, flush, sat_en, coef_wr_en, coef_wr_addr, coef_wr_data,
        output signal_lag, signal_align, ready, busy, overrun, wr_reject
    );
endinterface

// File: rtl/lag_generator_fir.sv
// rtl/lag_generator_fir.sv - fixed-point FIR echo generator, one shared MAC, one tap per cycle
module lag_generator_fir #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    parameter int TAPS      = 16
) (
    input  logic               clk_operation,
    input  logic               rst,
    lag_generator_fir_if.slave bus
);
    localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
    localparam int RW    = ACC_W + 1;
    localparam int PW    = DATA_W + COEF_W;

    localparam logic [AW-1:0]        LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]          TAPS_V = (AW + 1)'(TAPS);
    localparam logic signed [RW-1:0] HALF   = RW'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [RW-1:0] MAXV   = RW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [RW-1:0] MINV   = ~MAXV;

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] hist [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            head;
    logic [AW-1:0]            k;
    logic [AW-1:0]            rd_idx;
    logic signed [DATA_W-1:0] pend_align;
    logic                     pend_wr;
    logic [AW-1:0]            pend_addr;
    logic signed [COEF_W-1:0] pend_data;

    logic                     start;
    logic                     wr_ok;
    logic signed [PW-1:0]     prod;
    logic signed [RW-1:0]     rnd;
    logic signed [DATA_W-1:0] lag_nxt;

    assign start    = (state == IDLE) && bus.enable;
    assign wr_ok    = (state == IDLE) && ({1'b0, bus.coef_wr_addr} < TAPS_V);
    assign prod     = coef[k] * hist[rd_idx];
    assign rnd      = (RW'(acc) + HALF) >>> COEF_FRAC;
    assign bus.busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.enable) state_nxt = MAC;
            MAC:     if (k == LAST) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lag_nxt = rnd[DATA_W-1:0];
        if (bus.sat_en) begin
            if (rnd > MAXV)
                lag_nxt = MAXV[DATA_W-1:0];
            else if (rnd < MINV)
                lag_nxt = MINV[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
            acc              <= '0;
            head             <= '0;
            k                <= '0;
            rd_idx           <= '0;
            pend_align       <= '0;
            pend_wr          <= 1'b0;
            pend_addr        <= '0;
            pend_data        <= '0;
            bus.signal_lag   <= '0;
            bus.signal_align <= '0;
            bus.ready        <= 1'b0;
            bus.overrun      <= 1'b0;
            bus.wr_reject    <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.ready     <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.wr_reject <= 1'b0;

            // Flush clears first so a simultaneous enable lands in an empty history.
            if ((state == IDLE) && bus.flush) begin
                for (int i = 0; i < TAPS; i++)
                    hist[i] <= '0;
            end
            if (start) begin
                hist[head] <= bus.signal;
                pend_align <= bus.signal;
                acc        <= '0;
                k          <= '0;
                rd_idx     <= head;
            end
            if (bus.enable && (state != IDLE))
                bus.overrun <= 1'b1;

            // A write arriving with enable is parked until ROUND so this run sees the old value.
            if (bus.coef_wr_en) begin
                if (!wr_ok) begin
                    bus.wr_reject <= 1'b1;
                end else if (bus.enable) begin
                    pend_wr   <= 1'b1;
                    pend_addr <= bus.coef_wr_addr;
                    pend_data <= bus.coef_wr_data;
                end else begin
                    coef[bus.coef_wr_addr] <= bus.coef_wr_data;
                end
            end

            if (state == MAC) begin
                acc    <= acc + ACC_W'(prod);
                k      <= k + AW'(1);
                rd_idx <= (rd_idx == '0) ? LAST : rd_idx - AW'(1);
            end

            if (state == ROUND) begin
                bus.signal_lag   <= lag_nxt;
                bus.signal_align <= pend_align;
                bus.ready        <= 1'b1;
                head             <= (head == LAST) ? '0 : head + AW'(1);
                if (pend_wr)
                    coef[pend_addr] <= pend_data;
                pend_wr <= 1'b0;
            end
        end
    end
endmodule
